// File: rtl/mips_register_dumper_if.sv
// Bundle between the register dumper, the register file read ports and the word consumer.
// The master side is the dumper; the slave side is whoever feeds read data and accepts words.
interface mips_register_dumper_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;

    modport master (
        input  start, read_data_1, read_data_2, out_ready,
        output read_reg_1, read_reg_2, out_valid, out_data, out_index, busy, done
    );

    modport slave (
        output start, read_data_1, read_data_2, out_ready,
        input  read_reg_1, read_reg_2, out_valid, out_data, out_index, busy, done
    );
endinterface

// File: rtl/mips_register_dumper.sv
// Walks the register file two registers per read cycle and streams each value out
// over valid/ready, tagged with its register index, then pulses done.
module mips_register_dumper #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_register_dumper_if.master bus
);
    localparam int              K_W    = ADDR_W - 1;
    localparam logic [K_W-1:0]  LAST_K = K_W'(NUM_REGS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND_A,
        S_SEND_B,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [K_W-1:0]    r_k;
    logic [DATA_W-1:0] r_word_a;
    logic [DATA_W-1:0] r_word_b;
    logic [ADDR_W-1:0] r_read_reg_1;
    logic [ADDR_W-1:0] r_read_reg_2;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_busy;
    logic              r_done;

    logic [K_W-1:0]    w_k_next;
    logic [DATA_W-1:0] w_out_data;

    assign w_k_next = r_k + K_W'(1);

    // NOTE: every sequential register uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the captured words are reset too, so a dump abandoned by reset leaves nothing stale.
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_word_a     <= '0;
            r_word_b     <= '0;
            r_read_reg_1 <= '0;
            r_read_reg_2 <= '0;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state      <= S_READ;
                        r_k          <= '0;
                        r_read_reg_1 <= ADDR_W'(0);
                        r_read_reg_2 <= ADDR_W'(1);
                        r_busy       <= 1'b1;
                    end
                end
                S_READ: begin
                    r_word_a    <= bus.read_data_1;
                    r_word_b    <= bus.read_data_2;
                    r_out_valid <= 1'b1;
                    r_out_index <= {r_k, 1'b0};
                    r_state     <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (bus.out_ready) begin
                        r_out_index <= {r_k, 1'b1};
                        r_state     <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_k == LAST_K) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Next pair's addresses are set up here so READ drives them from flops.
                            r_k          <= w_k_next;
                            r_read_reg_1 <= {w_k_next, 1'b0};
                            r_read_reg_2 <= {w_k_next, 1'b1};
                            r_state      <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the default assignment up front keeps this mux from inferring a latch.
    always_comb begin
        w_out_data = '0;
        case (r_state)
            S_SEND_A: w_out_data = r_word_a;
            S_SEND_B: w_out_data = r_word_b;
            default:  ;
        endcase
    end

    assign bus.read_reg_1 = r_read_reg_1;
    assign bus.read_reg_2 = r_read_reg_2;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.out_index  = r_out_index;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_mips_register_dumper.sv
// Directed bench for mips_register_dumper: a register file model drives the read ports,
// a stream model checks every offered word, and directed tests pin latency and edge cases.
module tb_mips_register_dumper;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_register_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips_register_dumper #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Register file model: combinational reads, write on posedge.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              preload;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h1000_0000 + i;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign bus.read_data_1 = regs[bus.read_reg_1];
    assign bus.read_data_2 = regs[bus.read_reg_2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream model: words must appear in order 0..NUM_REGS-1 with the expected contents,
    // held stable under backpressure, and every done must close a complete dump.
    logic [DATA_W-1:0] exp_data [NUM_REGS];
    int                exp_idx  = 0;
    int                words    = 0;
    int                done_cnt = 0;

    initial begin : compare
        bit                prev_stall;
        logic [ADDR_W-1:0] prev_idx;
        logic [DATA_W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_idx   = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_idx    = 0;
                words      = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_index", 32'(bus.out_index), 32'(prev_idx));
                    check("stall_data", bus.out_data, prev_data);
                end
                if (bus.out_valid) begin
                    check("stream_index", 32'(bus.out_index), 32'(exp_idx));
                    check("stream_data", bus.out_data, exp_data[bus.out_index]);
                    check("valid_implies_busy", 32'(bus.busy), 32'd1);
                    prev_stall = !bus.out_ready;
                    prev_idx   = bus.out_index;
                    prev_data  = bus.out_data;
                    if (bus.out_ready) begin
                        exp_idx++;
                        words++;
                    end
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus.done) begin
                    check("words_per_dump", 32'(words), 32'(NUM_REGS));
                    done_cnt++;
                    words   = 0;
                    exp_idx = 0;
                end
            end
        end
    end

    typedef struct {
        int          stall_a_idx;
        int          stall_a_len;
        int          stall_b_idx;
        int          stall_b_len;
        int          restart_a;
        int          restart_b;
        int          write_at_pair;
        int          watch_idx;
        logic [31:0] watch_val;
    } dump_cfg_t;

    function automatic dump_cfg_t plain_cfg();
        dump_cfg_t c;
        c.stall_a_idx   = -1;
        c.stall_a_len   = 0;
        c.stall_b_idx   = -1;
        c.stall_b_len   = 0;
        c.restart_a     = -1;
        c.restart_b     = -1;
        c.write_at_pair = -1;
        c.watch_idx     = -1;
        c.watch_val     = '0;
        return c;
    endfunction

    // Called just after a posedge with the DUT idle; returns the cycle number (1 = the
    // cycle right after the start edge) in which done was seen, or -1 on timeout.
    task automatic run_dump(input dump_cfg_t cfg, output int done_cycle);
        int t0;
        int stall_left;
        int base_done;
        bit used_a;
        bit used_b;
        bit watched;
        base_done  = done_cnt;
        stall_left = 0;
        used_a     = 1'b0;
        used_b     = 1'b0;
        watched    = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t0 = cyc;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("no_valid_in_read", 32'(bus.out_valid), 32'd0);
        done_cycle = -1;
        for (int n = 0; n < 200 && done_cycle < 0; n++) begin
            bus.start = 1'b0;
            we        = 1'b0;
            if (bus.out_valid && int'(bus.out_index) == cfg.watch_idx && !watched) begin
                check("watch_data", bus.out_data, cfg.watch_val);
                watched = 1'b1;
            end
            if (bus.out_valid && (int'(bus.out_index) == cfg.restart_a ||
                                  int'(bus.out_index) == cfg.restart_b))
                bus.start = 1'b1;
            if (cfg.write_at_pair >= 0 && bus.busy && !bus.out_valid && !bus.done &&
                int'(bus.read_reg_1) == 2 * cfg.write_at_pair) begin
                we = 1'b1;
                wa = ADDR_W'(2 * cfg.write_at_pair + 1);
                wd = 32'hDEAD_BEEF;
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (bus.out_valid && int'(bus.out_index) == cfg.stall_a_idx && !used_a) begin
                bus.out_ready = 1'b0;
                stall_left    = cfg.stall_a_len - 1;
                used_a        = 1'b1;
            end else if (bus.out_valid && int'(bus.out_index) == cfg.stall_b_idx && !used_b) begin
                bus.out_ready = 1'b0;
                stall_left    = cfg.stall_b_len - 1;
                used_b        = 1'b1;
            end else begin
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (bus.done) done_cycle = cyc - t0 + 1;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        we            = 1'b0;
        if (cfg.watch_idx >= 0) check("watch_seen", 32'(watched), 32'd1);
        @(posedge clk); #1;
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("done_single_cycle", 32'(bus.done), 32'd0);
        check("done_count", 32'(done_cnt - base_done), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("no_queued_dump", 32'(bus.busy), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        dump_cfg_t cfg;
        int        dc;
        int        d1;
        int        d2;
        int        since;
        bit        found;

        reset         = 1'b1;
        preload       = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        we            = 1'b0;
        wa            = '0;
        wd            = '0;
        for (int i = 0; i < NUM_REGS; i++) exp_data[i] = 32'h1000_0000 + i;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_read_reg_1", 32'(bus.read_reg_1), 32'd0);
        check("rst_read_reg_2", 32'(bus.read_reg_2), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full dump with the consumer always ready.
        cfg           = plain_cfg();
        cfg.watch_idx = 31;
        cfg.watch_val = 32'h1000_001F;
        run_dump(cfg, dc);
        check("t1_done_cycle", 32'(dc), 32'd49);

        // Two stalls: 5 cycles on index 6, 3 cycles on index 7.
        cfg             = plain_cfg();
        cfg.stall_a_idx = 6;
        cfg.stall_a_len = 5;
        cfg.stall_b_idx = 7;
        cfg.stall_b_len = 3;
        cfg.watch_idx   = 7;
        cfg.watch_val   = 32'h1000_0007;
        run_dump(cfg, dc);
        check("t2_done_cycle", 32'(dc), 32'd57);

        // Start pulses during a dump are ignored.
        cfg           = plain_cfg();
        cfg.restart_a = 4;
        cfg.restart_b = 20;
        run_dump(cfg, dc);
        check("t3_done_cycle", 32'(dc), 32'd49);

        // Reset while index 10 is being offered abandons the dump.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (bus.out_valid && bus.out_index == ADDR_W'(10)) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("t4_reset_trigger_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4_valid_after_reset", 32'(bus.out_valid), 32'd0);
        check("t4_busy_after_reset", 32'(bus.busy), 32'd0);
        check("t4_index_after_reset", 32'(bus.out_index), 32'd0);
        check("t4_read_reg_1_after_reset", 32'(bus.read_reg_1), 32'd0);
        @(posedge clk); #1;
        cfg           = plain_cfg();
        cfg.watch_idx = 0;
        cfg.watch_val = 32'h1000_0000;
        run_dump(cfg, dc);
        check("t4_done_cycle", 32'(dc), 32'd49);

        // Write to register 9 on the capture edge of pair 4: the old value is dumped.
        cfg               = plain_cfg();
        cfg.write_at_pair = 4;
        cfg.watch_idx     = 9;
        cfg.watch_val     = 32'h1000_0009;
        run_dump(cfg, dc);
        check("t5a_done_cycle", 32'(dc), 32'd49);
        exp_data[9]   = 32'hDEAD_BEEF;
        cfg           = plain_cfg();
        cfg.watch_idx = 9;
        cfg.watch_val = 32'hDEAD_BEEF;
        run_dump(cfg, dc);
        check("t5b_done_cycle", 32'(dc), 32'd49);

        // start held high: dumps run back to back with one idle cycle between.
        d1        = -1;
        d2        = -1;
        since     = -1;
        bus.start = 1'b1;
        for (int n = 0; n < 300 && d2 < 0; n++) begin
            @(posedge clk); #1;
            if (since >= 0) since++;
            if (since == 1) check("t6_idle_gap", 32'(bus.busy), 32'd0);
            if (since == 2) check("t6_restart_busy", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                if (d1 < 0) begin
                    d1    = cyc;
                    since = 0;
                end else begin
                    d2 = cyc;
                end
            end
        end
        bus.start = 1'b0;
        check("t6_done_spacing", 32'(d2 - d1), 32'd50);
        repeat (4) @(posedge clk);
        #1;
        check("t6_idle_at_end", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
